// File: rtl/led_fade_controller_if.sv
// Bus bundle for led_fade_controller: config port, CPU device-bus request and LED device drive.
// The irq wire exists only when LED_FADE_IRQ_EN is defined.
interface led_fade_controller_if;
  logic       cfg_enable;
  logic       cfg_mode;
  logic [4:0] cfg_address;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       cpu_req;
  logic [3:0] cpu_address;
  logic       cpu_mode;
  logic [7:0] cpu_data;
  logic       cpu_grant;
  logic [3:0] dev_address;
  logic       dev_enable;
  logic       dev_mode;
  logic [7:0] dev_data;
`ifdef LED_FADE_IRQ_EN
  logic       irq;
`endif

  modport master (
    output cfg_enable, cfg_mode, cfg_address, cfg_wdata,
    output cpu_req, cpu_address, cpu_mode, cpu_data,
    input  cfg_rdata, cpu_grant, dev_address, dev_enable, dev_mode, dev_data
`ifdef LED_FADE_IRQ_EN
    , input irq
`endif
  );

  modport slave (
    input  cfg_enable, cfg_mode, cfg_address, cfg_wdata,
    input  cpu_req, cpu_address, cpu_mode, cpu_data,
    output cfg_rdata, cpu_grant, dev_address, dev_enable, dev_mode, dev_data
`ifdef LED_FADE_IRQ_EN
    , output irq
`endif
  );
endinterface

// File: rtl/led_fade_controller.sv
// Fades NUM_CH LED channels toward programmed targets, writing each change to the LED device bus.
// The CPU always wins the device bus. Optional completion interrupt: define LED_FADE_IRQ_EN.
module led_fade_controller #(
  parameter int NUM_CH = 10,
  parameter int DIV_W  = 8
) (
  input logic                  clk,
  input logic                  reset,
  led_fade_controller_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_SCAN = 2'd2, S_WRITE = 2'd3} state_t;
  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  state_t           r_state;
  logic [7:0]       r_target  [NUM_CH];
  logic [7:0]       r_current [NUM_CH];
  logic [7:0]       r_step;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_run;
  logic             r_sync;
  logic [3:0]       r_ch;
  logic             r_dev_en;
  logic [3:0]       r_dev_addr;
  logic [7:0]       r_dev_data;
  logic [7:0]       r_rdata;
  logic             w_cfg_wr;
  logic             w_cfg_rd;
  logic             w_run_nxt;
  logic             w_all_done;
  logic             w_irq_bit;
  logic             w_busy;
  logic [7:0]       w_cur;
  logic [7:0]       w_tgt;
  logic [7:0]       w_nxt;
  logic [7:0]       w_rdata;
  logic [8:0]       w_up;

  assign w_cfg_wr  = bus.cfg_enable & ~bus.cfg_mode;
  assign w_cfg_rd  = bus.cfg_enable & bus.cfg_mode;
  // Look ahead at run so that clearing it drops a pending write on the very same edge.
  assign w_run_nxt = (w_cfg_wr && (bus.cfg_address == 5'h12)) ? bus.cfg_wdata[0] : r_run;
  assign w_busy    = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_target[i] <= 8'h00;
      r_step <= 8'h01;
      r_div  <= '0;
      r_run  <= 1'b0;
    end else if (w_cfg_wr) begin
      if (bus.cfg_address < 5'(NUM_CH)) begin
        r_target[bus.cfg_address[3:0]] <= bus.cfg_wdata;
      end else begin
        case (bus.cfg_address)
          5'h10:   r_step <= bus.cfg_wdata;
          5'h11:   r_div  <= DIV_W'(bus.cfg_wdata);
          5'h12:   r_run  <= bus.cfg_wdata[0];
          default: r_run  <= r_run;
        endcase
      end
    end
  end

  always_comb begin
    w_cur = r_current[r_ch];
    w_tgt = r_target[r_ch];
    w_up  = {1'b0, w_cur} + {1'b0, r_step};
    if (r_step == 8'h00) begin
      w_nxt = w_tgt;
    end else if (w_cur < w_tgt) begin
      w_nxt = (w_up > {1'b0, w_tgt}) ? w_tgt : w_up[7:0];
    end else if ({1'b0, w_cur} < ({1'b0, w_tgt} + {1'b0, r_step})) begin
      w_nxt = w_tgt;
    end else begin
      w_nxt = w_cur - r_step;
    end
  end

  always_comb begin
    w_all_done = 1'b1;
    for (int i = 0; i < NUM_CH; i++) w_all_done = w_all_done & (r_current[i] == r_target[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ch       <= 4'd0;
      r_sync     <= 1'b0;
      r_div_cnt  <= '0;
      r_dev_en   <= 1'b0;
      r_dev_addr <= 4'd0;
      r_dev_data <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) r_current[i] <= 8'h00;
    end else if (!w_run_nxt) begin
      // A write already visible this cycle with the bus free has reached the device.
      if ((r_state == S_WRITE) && !bus.cpu_req) r_current[r_ch] <= r_dev_data;
      r_state  <= S_IDLE;
      r_ch     <= 4'd0;
      r_sync   <= 1'b0;
      r_dev_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_run) begin
            r_state <= S_SCAN;
            r_ch    <= 4'd0;
            r_sync  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_div_cnt == r_div) begin
            r_state <= S_SCAN;
            r_ch    <= 4'd0;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_SCAN: begin
          if ((w_nxt != w_cur) || r_sync) begin
            r_state    <= S_WRITE;
            r_dev_en   <= 1'b1;
            r_dev_addr <= r_ch;
            r_dev_data <= w_nxt;
          end else if (r_ch == LAST_CH) begin
            r_state   <= S_WAIT;
            r_ch      <= 4'd0;
            r_sync    <= 1'b0;
            r_div_cnt <= '0;
          end else begin
            r_ch <= r_ch + 4'd1;
          end
        end
        S_WRITE: begin
          if (!bus.cpu_req) begin
            r_current[r_ch] <= r_dev_data;
            r_dev_en        <= 1'b0;
            if (r_ch == LAST_CH) begin
              r_state   <= S_WAIT;
              r_ch      <= 4'd0;
              r_sync    <= 1'b0;
              r_div_cnt <= '0;
            end else begin
              r_state <= S_SCAN;
              r_ch    <= r_ch + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LED_FADE_IRQ_EN
  logic r_irq;
  logic r_done_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq    <= 1'b0;
      r_done_d <= 1'b1;
    end else begin
      r_done_d <= w_all_done;
      if (w_all_done && !r_done_d && r_run) begin
        r_irq <= 1'b1;
      end else if (w_cfg_wr && (bus.cfg_address == 5'h13)) begin
        r_irq <= 1'b0;
      end
    end
  end
  assign w_irq_bit = r_irq;
  assign bus.irq   = r_irq;
`else
  assign w_irq_bit = 1'b0;
`endif

  always_comb begin
    w_rdata = 8'h00;
    if (bus.cfg_address < 5'(NUM_CH)) begin
      w_rdata = r_target[bus.cfg_address[3:0]];
    end else begin
      case (bus.cfg_address)
        5'h10:   w_rdata = r_step;
        5'h11:   w_rdata = 8'(r_div);
        5'h12:   w_rdata = {7'd0, r_run};
        5'h13:   w_rdata = {5'd0, w_irq_bit, w_all_done, w_busy};
        default: w_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 8'h00;
    end else if (w_cfg_rd) begin
      r_rdata <= w_rdata;
    end
  end

  assign bus.cfg_rdata   = r_rdata;
  assign bus.cpu_grant   = bus.cpu_req;
  assign bus.dev_enable  = bus.cpu_req ? 1'b1 : r_dev_en;
  assign bus.dev_address = bus.cpu_req ? bus.cpu_address : r_dev_addr;
  assign bus.dev_mode    = bus.cpu_req ? bus.cpu_mode : 1'b0;
  assign bus.dev_data    = bus.cpu_req ? bus.cpu_data : r_dev_data;
endmodule
